// File: rtl/multicycle_cu.sv
// Multi-cycle MIPS control unit: sequences IF/ID/EXE/MEM/WB and counts retired instructions.
// Optional MEM wait states via MemReady when MCU_MEM_STALL_EN is defined.

`ifndef ALU_ADD
`define ALU_ADD 3'b000
`endif
`ifndef ALU_SUB
`define ALU_SUB 3'b001
`endif
`ifndef ALU_SLL
`define ALU_SLL 3'b010
`endif
`ifndef ALU_OR
`define ALU_OR 3'b011
`endif
`ifndef ALU_AND
`define ALU_AND 3'b100
`endif
`ifndef ALU_SLT
`define ALU_SLT 3'b101
`endif
`ifndef PC_NEXT_INS
`define PC_NEXT_INS 2'b00
`endif
`ifndef PC_REL_JMP
`define PC_REL_JMP 2'b01
`endif
`ifndef PC_ABS_JMP
`define PC_ABS_JMP 2'b10
`endif
`ifndef PC_HALT
`define PC_HALT 2'b11
`endif
`ifndef ALU_FROM_DATA
`define ALU_FROM_DATA 1'b0
`endif
`ifndef ALU_FROM_SA
`define ALU_FROM_SA 1'b1
`endif
`ifndef ALU_FROM_IMMD
`define ALU_FROM_IMMD 1'b1
`endif
`ifndef DB_FROM_ALU
`define DB_FROM_ALU 1'b0
`endif
`ifndef DB_FROM_DM
`define DB_FROM_DM 1'b1
`endif
`ifndef REG_FROM_RT
`define REG_FROM_RT 1'b0
`endif
`ifndef REG_FROM_RD
`define REG_FROM_RD 1'b1
`endif
`ifndef EXT_ZERO
`define EXT_ZERO 1'b0
`endif
`ifndef EXT_SIGN
`define EXT_SIGN 1'b1
`endif

module multicycle_cu #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nReset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             Sign,
`ifdef MCU_MEM_STALL_EN
  input  logic             MemReady,
`endif
  output logic             PCWre,
  output logic             IRWre,
  output logic             ALUSrcA,
  output logic             ALUSrcB,
  output logic             DB,
  output logic             RegDst,
  output logic             ExtSel,
  output logic             RegWre,
  output logic             nRD,
  output logic             nWR,
  output logic [1:0]       PCSel,
  output logic [2:0]       ALUOp,
  output logic [2:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    S_IF     = 3'd0,
    S_ID     = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_t;

  state_t state, state_next;

  logic is_rtype, is_j, is_beq, is_bne, is_bgtz, is_addi, is_ori, is_lw, is_sw, is_halt;
  logic is_branch, is_sll, writes_reg, branch_taken, mem_ready;
  logic r_known;
  logic [2:0] r_alu_op, exe_alu_op;

`ifdef MCU_MEM_STALL_EN
  assign mem_ready = MemReady;
`else
  assign mem_ready = 1'b1;
`endif

  assign is_rtype  = (Opcode == OP_RTYPE);
  assign is_j      = (Opcode == OP_J);
  assign is_beq    = (Opcode == OP_BEQ);
  assign is_bne    = (Opcode == OP_BNE);
  assign is_bgtz   = (Opcode == OP_BGTZ);
  assign is_addi   = (Opcode == OP_ADDI);
  assign is_ori    = (Opcode == OP_ORI);
  assign is_lw     = (Opcode == OP_LW);
  assign is_sw     = (Opcode == OP_SW);
  assign is_halt   = (Opcode == OP_HALT);
  assign is_branch = is_beq | is_bne | is_bgtz;
  assign is_sll    = is_rtype & (Funct == FN_SLL);

  always_comb begin
    r_known  = 1'b1;
    r_alu_op = `ALU_ADD;
    case (Funct)
      FN_ADD:  r_alu_op = `ALU_ADD;
      FN_SUB:  r_alu_op = `ALU_SUB;
      FN_AND:  r_alu_op = `ALU_AND;
      FN_OR:   r_alu_op = `ALU_OR;
      FN_SLL:  r_alu_op = `ALU_SLL;
      FN_SLT:  r_alu_op = `ALU_SLT;
      default: r_known  = 1'b0;
    endcase
  end

  // Operation held from EXE through MEM/WB so the ALU result stays valid.
  always_comb begin
    exe_alu_op = `ALU_ADD;
    if (is_rtype)
      exe_alu_op = r_alu_op;
    else if (is_ori)
      exe_alu_op = `ALU_OR;
  end

  assign writes_reg   = is_lw | is_addi | is_ori | (is_rtype & r_known);
  assign branch_taken = (is_beq & Zero) | (is_bne & ~Zero) | (is_bgtz & ~Sign & ~Zero);

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset)
      state <= S_IF;
    else
      state <= state_next;
  end

  // Every output is gated by nReset so reset takes effect without waiting for the clock.
  always_comb begin
    state_next = state;
    PCWre      = 1'b0;
    IRWre      = 1'b0;
    RegWre     = 1'b0;
    nRD        = 1'b1;
    nWR        = 1'b1;
    PCSel      = `PC_NEXT_INS;
    ALUOp      = `ALU_ADD;
    ALUSrcA    = `ALU_FROM_DATA;
    ALUSrcB    = `ALU_FROM_DATA;
    DB         = `DB_FROM_ALU;
    RegDst     = `REG_FROM_RD;
    ExtSel     = `EXT_SIGN;
    if (nReset) begin
      if (is_sll)
        ALUSrcA = `ALU_FROM_SA;
      if (is_addi | is_ori | is_lw | is_sw)
        ALUSrcB = `ALU_FROM_IMMD;
      if (is_lw)
        DB = `DB_FROM_DM;
      if (is_lw | is_addi | is_ori)
        RegDst = `REG_FROM_RT;
      if (is_ori)
        ExtSel = `EXT_ZERO;

      case (state)
        S_IF: begin
          IRWre      = 1'b1;
          state_next = S_ID;
        end
        S_ID: begin
          if (is_j) begin
            PCSel      = `PC_ABS_JMP;
            PCWre      = 1'b1;
            state_next = S_IF;
          end else if (is_halt) begin
            PCSel      = `PC_HALT;
            state_next = S_HALTED;
          end else begin
            state_next = S_EXE;
          end
        end
        S_EXE: begin
          if (is_branch) begin
            ALUOp      = `ALU_SUB;
            PCSel      = branch_taken ? `PC_REL_JMP : `PC_NEXT_INS;
            PCWre      = 1'b1;
            state_next = S_IF;
          end else begin
            ALUOp      = exe_alu_op;
            state_next = (is_lw | is_sw) ? S_MEM : S_WB;
          end
        end
        S_MEM: begin
          ALUOp = exe_alu_op;
          if (is_lw) begin
            nRD = 1'b0;
            if (mem_ready)
              state_next = S_WB;
          end else if (is_sw) begin
            nWR = 1'b0;
            if (mem_ready) begin
              PCWre      = 1'b1;
              state_next = S_IF;
            end
          end else begin
            state_next = S_IF;
          end
        end
        S_WB: begin
          ALUOp      = exe_alu_op;
          RegWre     = writes_reg;
          PCWre      = 1'b1;
          state_next = S_IF;
        end
        S_HALTED: begin
          PCSel      = `PC_HALT;
          state_next = S_HALTED;
        end
        default: state_next = S_IF;
      endcase
    end
  end

  assign State = state;

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset)
      InstrCount <= '0;
    else if (PCWre)
      InstrCount <= InstrCount + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule
